// File: rtl/fc_ctrl_pkg.sv
// Shared types and helpers for the fully-connected input-buffer sequencer.
package fc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } fc_ibuf_state_t;

  // Width helper that never returns zero, so single-entry ranges still get a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module fc_ctrl_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count while enabled, stick at all-ones, clear on reset or explicit clear.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fc_ibuf_ctrl.sv
// Bit-serial input buffer sequencer for one fully-connected layer.
// Loads FIFO_LENGTH beats, then for each bit plane issues one crossbar
// compute per buffer address, shifting the buffer between planes.
// Optional performance counters are enabled by defining FC_IBUF_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | waiting for i_start
// LOAD  | accepting upstream beats into the buffer
// ISSUE | one-cycle crossbar start for the current address/plane
// WAIT  | waiting for the crossbar done pulse
// SHIFT | one-cycle buffer shift to the next bit plane
// DONE  | layer complete, holding o_done until acknowledged
module fc_ibuf_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int FIFO_LENGTH = 4,
  parameter int NUM_ADDR    = 2,
  parameter int ADDR_W      = clog2_min1(NUM_ADDR),
  parameter int BIT_W       = clog2_min1(DATA_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_we,
  output logic              o_se,
  output logic [ADDR_W-1:0] o_ibuf_addr,
  output logic              o_xbar_start,
  input  logic              i_xbar_done,
  output logic [BIT_W-1:0]  o_bit_idx,
  output logic              o_last_bit,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_done_ack
`ifdef FC_IBUF_CTRL_PERF_EN
  ,
  output logic [31:0]       o_cycle_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam int LOAD_W = clog2_min1(FIFO_LENGTH);

  fc_ibuf_state_t state_q, state_d;

  logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  logic load_last;
  logic addr_last;
  logic bit_last;

  assign load_last = (load_cnt_q == LOAD_W'(FIFO_LENGTH - 1));
  assign addr_last = (addr_q == ADDR_W'(NUM_ADDR - 1));
  assign bit_last  = (bit_q == BIT_W'(DATA_SIZE - 1));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      addr_q     <= '0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      addr_q     <= addr_d;
      bit_q      <= bit_d;
    end
  end

  // Next-state logic; i_xbar_done only matters in WAIT, i_start only in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (i_start) state_d = LOAD;
      LOAD:  if (i_valid && load_last) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (i_xbar_done) begin
          if (!addr_last)     state_d = ISSUE;
          else if (!bit_last) state_d = SHIFT;
          else                state_d = DONE;
        end
      end
      SHIFT: state_d = ISSUE;
      DONE:  if (i_done_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load count, address and bit-plane updates; address/bit change only after done is seen.
  always_comb begin
    load_cnt_d = load_cnt_q;
    addr_d     = addr_q;
    bit_d      = bit_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          load_cnt_d = '0;
          addr_d     = '0;
          bit_d      = '0;
        end
      end
      LOAD:  if (i_valid) load_cnt_d = load_cnt_q + LOAD_W'(1);
      WAIT:  if (i_xbar_done && !addr_last) addr_d = addr_q + ADDR_W'(1);
      SHIFT: begin
        bit_d  = bit_q + BIT_W'(1);
        addr_d = '0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; gated by rst so a reset cycle never emits a strobe.
  always_comb begin
    o_ready      = 1'b0;
    o_se         = 1'b0;
    o_xbar_start = 1'b0;
    o_done       = 1'b0;
    o_busy       = 1'b0;
    if (!rst) begin
      o_ready      = (state_q == LOAD);
      o_se         = (state_q == SHIFT);
      o_xbar_start = (state_q == ISSUE);
      o_done       = (state_q == DONE);
      o_busy       = (state_q != IDLE);
    end
    o_we       = o_ready & i_valid;
    o_last_bit = !rst && bit_last;
  end

  assign o_ibuf_addr = addr_q;
  assign o_bit_idx   = bit_q;

`ifdef FC_IBUF_CTRL_PERF_EN
  logic perf_clr;
  assign perf_clr = (state_q == IDLE) && i_start;

  fc_ctrl_sat_cnt #(.WIDTH(32)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (perf_clr),
    .en_i  (state_q != IDLE),
    .cnt_o (o_cycle_cnt)
  );

  fc_ctrl_sat_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (perf_clr),
    .en_i  ((state_q == LOAD) && !i_valid),
    .cnt_o (o_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fc_ibuf_ctrl.sv
// Directed self-checking bench for fc_ibuf_ctrl (DATA_SIZE=4, FIFO_LENGTH=3,
// NUM_ADDR=2) plus a degenerate DATA_SIZE=1, NUM_ADDR=1 instance.
module tb_fc_ibuf_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_start, i_valid, i_xbar_done, i_done_ack;
  logic o_ready, o_we, o_se, o_xbar_start, o_last_bit, o_busy, o_done;
  logic [0:0] o_ibuf_addr;
  logic [1:0] o_bit_idx;

  logic d_start, d_valid, d_xdone, d_ack;
  logic d_ready, d_we, d_se, d_xs, d_last, d_busy, d_done;
  logic [0:0] d_addr;
  logic [0:0] d_bit;

`ifdef FC_IBUF_CTRL_PERF_EN
  logic [31:0] o_cycle_cnt, o_stall_cnt, d_cycle_cnt, d_stall_cnt;
`endif

  fc_ibuf_ctrl #(.DATA_SIZE(4), .FIFO_LENGTH(3), .NUM_ADDR(2)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid),
    .o_ready(o_ready), .o_we(o_we), .o_se(o_se), .o_ibuf_addr(o_ibuf_addr),
    .o_xbar_start(o_xbar_start), .i_xbar_done(i_xbar_done),
    .o_bit_idx(o_bit_idx), .o_last_bit(o_last_bit), .o_busy(o_busy),
    .o_done(o_done), .i_done_ack(i_done_ack)
`ifdef FC_IBUF_CTRL_PERF_EN
    , .o_cycle_cnt(o_cycle_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );

  fc_ibuf_ctrl #(.DATA_SIZE(1), .FIFO_LENGTH(3), .NUM_ADDR(1)) dut_deg (
    .clk(clk), .rst(rst), .i_start(d_start), .i_valid(d_valid),
    .o_ready(d_ready), .o_we(d_we), .o_se(d_se), .o_ibuf_addr(d_addr),
    .o_xbar_start(d_xs), .i_xbar_done(d_xdone),
    .o_bit_idx(d_bit), .o_last_bit(d_last), .o_busy(d_busy),
    .o_done(d_done), .i_done_ack(d_ack)
`ifdef FC_IBUF_CTRL_PERF_EN
    , .o_cycle_cnt(d_cycle_cnt), .o_stall_cnt(d_stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int n_we, n_xs, n_se, dn_xs, dn_se;
  int overlap;

  // Edge-sampled event counters.
  always @(posedge clk) begin
    if (o_we) n_we++;
    if (o_xbar_start) n_xs++;
    if (o_se) n_se++;
    if (o_we && o_se) overlap++;
    if (d_xs) dn_xs++;
    if (d_se) dn_se++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_we = 0; n_xs = 0; n_se = 0; dn_xs = 0; dn_se = 0; overlap = 0;
  endtask

  task automatic wait_xs();
    for (int t = 0; t < 8 && o_xbar_start !== 1'b1; t++) begin
      tick();
      settle();
    end
    check("xs_seen", o_xbar_start, 1);
  endtask

  // Start a layer and feed three back-to-back beats; ends sampled in ISSUE.
  task automatic load3();
    i_start = 1; tick(); i_start = 0; i_valid = 1; settle();
    check("load_we0", o_we, 1);
    tick(); settle(); check("load_we1", o_we, 1);
    tick(); settle(); check("load_we2", o_we, 1);
    tick(); i_valid = 0; settle();
    check("first_xs_lat", o_xbar_start, 1);
    check("we_out_load", o_we, 0);
  endtask

  // Serve computes first..7 with done 2 cycles after start; abort with rst at abort_k.
  task automatic run_computes(input int first, input int abort_k);
    for (int k = first; k < 8; k++) begin
      wait_xs();
      check("xs_addr", o_ibuf_addr, k % 2);
      check("xs_bit", o_bit_idx, k / 2);
      check("xs_last", o_last_bit, (k / 2 == 3) ? 1 : 0);
      tick();
      if (k == abort_k) begin
        rst = 1; settle();
        check("rst_xs", o_xbar_start, 0);
        check("rst_busy", o_busy, 0);
        tick(); rst = 0; settle();
        check("post_rst_busy", o_busy, 0);
        check("post_rst_addr", o_ibuf_addr, 0);
        check("post_rst_bit", o_bit_idx, 0);
        check("post_rst_se", o_se, 0);
        return;
      end
      tick(); i_xbar_done = 1; settle();
      check("wait_addr_stable", o_ibuf_addr, k % 2);
      tick(); i_xbar_done = 0; settle();
      if (k == 7) begin
        check("done_set", o_done, 1);
      end else if (k % 2 == 1) begin
        check("plane_se", o_se, 1);
        check("plane_we", o_we, 0);
        tick(); settle();
        check("plane_xs_lat", o_xbar_start, 1);
      end else begin
        check("next_xs_lat", o_xbar_start, 1);
      end
    end
  endtask

  task automatic ack_done();
    i_done_ack = 1; tick(); i_done_ack = 0; settle();
    check("ack_done_clr", o_done, 0);
    check("ack_idle", o_busy, 0);
  endtask

  initial begin
    logic [5:0] pat;
    rst = 1; i_start = 0; i_valid = 0; i_xbar_done = 0; i_done_ack = 0;
    d_start = 0; d_valid = 0; d_xdone = 0; d_ack = 0;
    clear_counts();
    tick(); tick(); settle();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ready", o_ready, 0);
    check("rst_addr", o_ibuf_addr, 0);
    check("rst_bit", o_bit_idx, 0);
    check("rst_last", o_last_bit, 0);
    check("rst_deg_last", d_last, 0);
    rst = 0; tick(); settle();
    check("deg_last_const", d_last, 1);

    // i_valid in IDLE has no effect
    i_valid = 1; settle();
    check("idle_we", o_we, 0);
    check("idle_ready", o_ready, 0);
    tick(); settle();
    check("idle_busy", o_busy, 0);
    i_valid = 0;

    // Nominal run
    clear_counts();
    load3();
    run_computes(0, -1);
    tick(); settle();
    check("done_held", o_done, 1);
    i_start = 1; tick(); i_start = 0; settle();
    check("done_ign_start", o_done, 1);
    ack_done();
    check("nom_we_cnt", n_we, 3);
    check("nom_xs_cnt", n_xs, 8);
    check("nom_se_cnt", n_se, 3);
    check("nom_overlap", overlap, 0);

    // Upstream bubbles and done aliasing
    clear_counts();
    pat = 6'b101001;  // bit i = i_valid in LOAD cycle i
    i_start = 1; tick(); i_start = 0;
    for (int i = 0; i < 6; i++) begin
      i_valid = pat[i]; settle();
      check("bub_we", o_we, pat[i]);
      tick();
    end
    i_valid = 0; settle();
    check("bub_xs_lat", o_xbar_start, 1);
`ifdef FC_IBUF_CTRL_PERF_EN
    check("bub_stall_cnt", o_stall_cnt, 3);
`endif
    i_xbar_done = 1; tick(); i_xbar_done = 0; i_start = 1; settle();
    check("alias_xs", o_xbar_start, 0);
    check("alias_addr", o_ibuf_addr, 0);
    check("alias_busy", o_busy, 1);
    tick(); i_start = 0; i_xbar_done = 1; settle();
    check("alias_wait_addr", o_ibuf_addr, 0);
    tick(); i_xbar_done = 0; settle();
    check("alias_adv_xs", o_xbar_start, 1);
    check("alias_adv_addr", o_ibuf_addr, 1);
    run_computes(1, -1);
    ack_done();
    check("bub_we_cnt", n_we, 3);
    check("bub_xs_cnt", n_xs, 8);

    // Reset mid-plane at bit 2, addr 1
    load3();
    run_computes(0, 5);
    clear_counts();
    tick(); tick(); tick(); settle();
    check("abort_xs_cnt", n_xs, 0);
    check("abort_se_cnt", n_se, 0);
    check("abort_we_cnt", n_we, 0);
    load3();
    run_computes(0, -1);
    ack_done();
    check("rerun_we_cnt", n_we, 3);
    check("rerun_xs_cnt", n_xs, 8);
    check("rerun_se_cnt", n_se, 3);

    // Degenerate DATA_SIZE=1, NUM_ADDR=1
    clear_counts();
    d_start = 1; tick(); d_start = 0; d_valid = 1;
    tick(); tick(); tick(); d_valid = 0; settle();
    check("deg_xs", d_xs, 1);
    check("deg_addr", d_addr, 0);
    check("deg_last", d_last, 1);
    tick(); d_xdone = 1; tick(); d_xdone = 0; settle();
    check("deg_done", d_done, 1);
    check("deg_se", d_se, 0);
    d_ack = 1; tick(); d_ack = 0; settle();
    check("deg_done_clr", d_done, 0);
    check("deg_xs_cnt", dn_xs, 1);
    check("deg_se_cnt", dn_se, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
